// File: rtl/cond_br_buffered.sv
`default_nettype none
// ============================================================================
// Module   : cond_br_buffered
// Purpose  : Elastic conditional branch. Branch conditions are queued in a
//            small FIFO so they may arrive ahead of their data. Each data
//            token is paired with the oldest queued condition and written to
//            a one-entry registered slot on the true or the false side.
//            Registering both output slots breaks the valid/ready path
//            between the comparator and the successors.
// Ports    : clk, rst (synchronous, active-low)
//            condition / condition_valid / condition_ready : 1-bit input token
//            data / data_valid / data_ready                : data input token
//            trueOut / trueOut_valid / trueOut_ready       : condition == 1
//            falseOut / falseOut_valid / falseOut_ready    : condition == 0
// Revision : 1.0 - initial release
// ============================================================================
module cond_br_buffered #(
    parameter int DATA_TYPE       = 32,
    parameter int COND_FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 condition,
    input  logic                 condition_valid,
    output logic                 condition_ready,
    input  logic [DATA_TYPE-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [DATA_TYPE-1:0] trueOut,
    output logic                 trueOut_valid,
    input  logic                 trueOut_ready,
    output logic [DATA_TYPE-1:0] falseOut,
    output logic                 falseOut_valid,
    input  logic                 falseOut_ready
);

    // A depth of one still needs a 1-bit pointer; it simply never moves.
    localparam int c_PTR_W = (COND_FIFO_DEPTH > 1) ? $clog2(COND_FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(COND_FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(COND_FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(COND_FIFO_DEPTH);

    logic [COND_FIFO_DEPTH-1:0] r_cond_mem;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_CNT_W-1:0]         r_count;

    logic                       r_true_valid;
    logic                       r_false_valid;
    logic [DATA_TYPE-1:0]       r_true_data;
    logic [DATA_TYPE-1:0]       r_false_data;

    logic                       w_full;
    logic                       w_empty;
    logic                       w_head;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_true_accept;
    logic                       w_false_accept;
    logic                       w_fire;
    logic                       w_fire_true;
    logic                       w_fire_false;

    // ------------------------------------------------------------------
    // Condition FIFO status and head selection
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Compare-based read mux keeps the index width independent of depth,
    // which matters for depth 1 and for non-power-of-two depths.
    always_comb begin
        w_head = 1'b0;
        for (int i = 0; i < COND_FIFO_DEPTH; i++) begin
            if (r_rd_ptr == c_PTR_W'(i)) begin
                w_head = r_cond_mem[i];
            end
        end
    end

    // No bypass on a full FIFO: readiness depends only on the stored count,
    // so condition_ready never waits on the data side.
    assign condition_ready = rst && !w_full;
    assign w_push          = condition_valid && condition_ready;

    // ------------------------------------------------------------------
    // Fire logic: a slot accepts when empty or draining this cycle
    // ------------------------------------------------------------------
    assign w_true_accept  = !r_true_valid  || trueOut_ready;
    assign w_false_accept = !r_false_valid || falseOut_ready;

    assign w_fire       = rst && !w_empty && data_valid &&
                          (w_head ? w_true_accept : w_false_accept);
    assign w_fire_true  = w_fire &&  w_head;
    assign w_fire_false = w_fire && !w_head;
    assign w_pop        = w_fire;
    assign data_ready   = w_fire;

    // ------------------------------------------------------------------
    // Condition FIFO storage, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cond_mem <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            for (int i = 0; i < COND_FIFO_DEPTH; i++) begin
                if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
                    r_cond_mem[i] <= condition;
                end
            end

            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slots. A reload in the same cycle as a drain keeps valid high,
    // giving one token per cycle per side. Data only changes on a reload,
    // so it is stable throughout a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_true_valid <= 1'b0;
            r_true_data  <= '0;
        end else if (w_fire_true) begin
            r_true_valid <= 1'b1;
            r_true_data  <= data;
        end else if (r_true_valid && trueOut_ready) begin
            r_true_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_false_valid <= 1'b0;
            r_false_data  <= '0;
        end else if (w_fire_false) begin
            r_false_valid <= 1'b1;
            r_false_data  <= data;
        end else if (r_false_valid && falseOut_ready) begin
            r_false_valid <= 1'b0;
        end
    end

    assign trueOut        = r_true_data;
    assign trueOut_valid  = r_true_valid;
    assign falseOut       = r_false_data;
    assign falseOut_valid = r_false_valid;

endmodule
`default_nettype wire

// File: tb/tb_cond_br_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_br_buffered
// Purpose  : Self-checking bench for cond_br_buffered. A depth-2 instance is
//            driven with directed sequences; a depth-3 instance is driven with
//            random tokens and readies and checked against an arrival-order
//            scoreboard (k-th data goes to the side named by k-th condition).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_br_buffered;

    logic clk;
    logic rst;

    // depth-2 instance signals
    logic        c2_cond, c2_cv, c2_cr;
    logic [31:0] d2_data;
    logic        d2_dv, d2_dr;
    logic [31:0] t2, f2;
    logic        t2v, t2r, f2v, f2r;

    // depth-3 instance signals
    logic        c3_cond, c3_cv, c3_cr;
    logic [31:0] d3_data;
    logic        d3_dv, d3_dr;
    logic [31:0] t3, f3;
    logic        t3v, t3r, f3v, f3r;

    int n_vec;
    int n_err;

    cond_br_buffered #(.DATA_TYPE(32), .COND_FIFO_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .condition(c2_cond), .condition_valid(c2_cv), .condition_ready(c2_cr),
        .data(d2_data), .data_valid(d2_dv), .data_ready(d2_dr),
        .trueOut(t2), .trueOut_valid(t2v), .trueOut_ready(t2r),
        .falseOut(f2), .falseOut_valid(f2v), .falseOut_ready(f2r)
    );

    cond_br_buffered #(.DATA_TYPE(32), .COND_FIFO_DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .condition(c3_cond), .condition_valid(c3_cv), .condition_ready(c3_cr),
        .data(d3_data), .data_valid(d3_dv), .data_ready(d3_dr),
        .trueOut(t3), .trueOut_valid(t3v), .trueOut_ready(t3r),
        .falseOut(f3), .falseOut_valid(f3v), .falseOut_ready(f3r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    localparam int N_RAND = 20;
    logic        conds [N_RAND];
    logic [31:0] datas [N_RAND];
    logic [31:0] exp_t [$];
    logic [31:0] exp_f [$];
    int          ci, di, nrecv;
    logic        t_stalled, f_stalled;
    logic [31:0] t_hold, f_hold;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0;
        c2_cond = 0; c2_cv = 0; d2_data = 0; d2_dv = 0; t2r = 1; f2r = 1;
        c3_cond = 0; c3_cv = 0; d3_data = 0; d3_dv = 0; t3r = 1; f3r = 1;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_true_valid", t2v, 0);
        chk("rst_false_valid", f2v, 0);
        chk("rst_true_data", t2, 0);
        chk("rst_false_data", f2, 0);
        c2_cv = 1; d2_dv = 1;
        settle();
        chk("rst_cond_ready_forced", c2_cr, 0);
        chk("rst_data_ready_forced", d2_dr, 0);
        c2_cv = 0; d2_dv = 0;
        rst = 1'b1;
        settle();
        chk("rst_release_cond_ready", c2_cr, 1);

        // ---------------- basic routing ----------------
        tick();
        c2_cond = 1; c2_cv = 1; d2_data = 32'h0000_00AA; d2_dv = 1;
        settle();
        chk("basic_data_wait_empty", d2_dr, 0);
        tick();
        c2_cv = 0;
        settle();
        chk("basic_fire", d2_dr, 1);
        tick();
        d2_dv = 0;
        chk("basic_true_valid", t2v, 1);
        chk("basic_true_data", t2, 32'hAA);
        chk("basic_false_quiet", f2v, 0);
        tick();
        chk("basic_true_drained", t2v, 0);

        // ---------------- early conditions ----------------
        c2_cond = 0; c2_cv = 1;
        settle();
        chk("early_cr0", c2_cr, 1);
        tick();
        c2_cond = 1;
        settle();
        chk("early_cr1", c2_cr, 1);
        tick();
        c2_cv = 0;
        settle();
        chk("early_full", c2_cr, 0);
        d2_data = 32'h11; d2_dv = 1;
        settle();
        chk("early_fire_11", d2_dr, 1);
        tick();
        chk("early_false_valid", f2v, 1);
        chk("early_false_data", f2, 32'h11);
        d2_data = 32'h22;
        settle();
        chk("early_fire_22", d2_dr, 1);
        tick();
        d2_dv = 0;
        chk("early_true_valid", t2v, 1);
        chk("early_true_data", t2, 32'h22);
        chk("early_false_drained", f2v, 0);
        tick();
        chk("early_true_drained", t2v, 0);

        // ---------------- side-stall isolation ----------------
        f2r = 0;
        c2_cond = 0; c2_cv = 1;
        tick();
        c2_cond = 1; d2_data = 32'h1; d2_dv = 1;
        settle();
        chk("stall_fire_1", d2_dr, 1);
        tick();
        c2_cond = 0; d2_data = 32'h2;
        settle();
        chk("stall_fire_2", d2_dr, 1);
        tick();
        c2_cv = 0; d2_data = 32'h3;
        settle();
        chk("stall_block_3", d2_dr, 0);
        chk("stall_false_parked_v", f2v, 1);
        chk("stall_false_parked_d", f2, 32'h1);
        chk("stall_true_v", t2v, 1);
        chk("stall_true_d", t2, 32'h2);
        tick();
        chk("stall_true_drained", t2v, 0);
        chk("stall_false_hold", f2, 32'h1);
        chk("stall_still_blocked", d2_dr, 0);
        f2r = 1;
        settle();
        chk("stall_release", d2_dr, 1);
        tick();
        d2_dv = 0;
        chk("stall_false_v3", f2v, 1);
        chk("stall_false_d3", f2, 32'h3);
        tick();
        chk("stall_false_drained", f2v, 0);

        // ---------------- replace-on-drain streaming ----------------
        c2_cond = 1; c2_cv = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            d2_data = i; d2_dv = 1; c2_cv = (i < 7);
            settle();
            chk("stream_fire", d2_dr, 1);
            tick();
            chk("stream_valid", t2v, 1);
            chk("stream_data", t2, i);
        end
        d2_dv = 0; c2_cv = 0;
        tick();
        chk("stream_end", t2v, 0);

        // ---------------- reset mid-operation ----------------
        t2r = 0;
        c2_cond = 1; c2_cv = 1;
        tick();
        c2_cond = 0; d2_data = 32'h55; d2_dv = 1;
        tick();
        c2_cond = 1; d2_dv = 0;
        tick();
        c2_cv = 0;
        settle();
        chk("midrst_full", c2_cr, 0);
        chk("midrst_slot_v", t2v, 1);
        chk("midrst_slot_d", t2, 32'h55);
        rst = 0; d2_data = 32'h99; d2_dv = 1;
        settle();
        chk("midrst_dr_forced", d2_dr, 0);
        tick();
        rst = 1; d2_dv = 0;
        chk("midrst_true_v", t2v, 0);
        chk("midrst_false_v", f2v, 0);
        chk("midrst_true_d", t2, 0);
        chk("midrst_false_d", f2, 0);
        settle();
        chk("midrst_cr", c2_cr, 1);
        d2_dv = 1;
        settle();
        chk("midrst_fifo_empty", d2_dr, 0);
        tick();
        d2_dv = 0; t2r = 1;
        chk("midrst_no_stale_t", t2v, 0);
        chk("midrst_no_stale_f", f2v, 0);

        // ---------------- odd depth, random tokens and readies ----------------
        for (int k = 0; k < N_RAND; k++) begin
            conds[k] = 1'($urandom_range(0, 1));
            datas[k] = $urandom;
        end
        ci = 0; di = 0; nrecv = 0;
        t_stalled = 0; f_stalled = 0; t_hold = 0; f_hold = 0;
        for (int cyc = 0; cyc < 2000 && nrecv < N_RAND; cyc++) begin
            c3_cv   = (ci < N_RAND) && ($urandom_range(0, 3) != 0);
            c3_cond = (ci < N_RAND) ? conds[ci] : 1'b0;
            d3_dv   = (di < N_RAND) && ($urandom_range(0, 3) != 0);
            d3_data = (di < N_RAND) ? datas[di] : 32'h0;
            t3r     = ($urandom_range(0, 2) != 0);
            f3r     = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (t_stalled) begin
                chk("rand_true_hold_v", t3v, 1);
                chk("rand_true_hold_d", t3, t_hold);
            end
            if (f_stalled) begin
                chk("rand_false_hold_v", f3v, 1);
                chk("rand_false_hold_d", f3, f_hold);
            end
            if (c3_cv && c3_cr) ci++;
            if (d3_dv && d3_dr) begin
                if (conds[di]) exp_t.push_back(datas[di]);
                else           exp_f.push_back(datas[di]);
                di++;
            end
            if (t3v && t3r) begin
                chk("rand_true_expected", exp_t.size() > 0, 1);
                if (exp_t.size() > 0) chk("rand_true_data", t3, exp_t.pop_front());
                nrecv++;
            end
            if (f3v && f3r) begin
                chk("rand_false_expected", exp_f.size() > 0, 1);
                if (exp_f.size() > 0) chk("rand_false_data", f3, exp_f.pop_front());
                nrecv++;
            end
            t_stalled = t3v && !t3r; t_hold = t3;
            f_stalled = f3v && !f3r; f_hold = f3;
            @(posedge clk);
            #1;
        end
        c3_cv = 0; d3_dv = 0;
        chk("rand_all_delivered", nrecv, N_RAND);
        chk("rand_conds_taken", ci, N_RAND);
        chk("rand_data_taken", di, N_RAND);
        chk("rand_true_leftover", exp_t.size(), 0);
        chk("rand_false_leftover", exp_f.size(), 0);
        t3r = 1; f3r = 1;
        tick();
        chk("rand_final_true_v", t3v, 0);
        chk("rand_final_false_v", f3v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
